// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types: raw fetch beat, queued instruction with
// predecode annotations, and the compressed-instruction test used by decode.
package riscv_pkg;

    localparam logic [31:0] ILEN_RVC = 32'd2;
    localparam logic [31:0] ILEN_RV  = 32'd4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ifu_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_compressed;
        logic [31:0] next_addr;
    } ifq_t;

    // Any encoding whose low two bits are not 2'b11 is a 16-bit RVC instruction.
    function automatic logic riscv_is_compressed(input logic [1:0] opc_lo);
        return (opc_lo != 2'b11);
    endfunction

endpackage

// File: rtl/riscv_ifq_if.sv
// Fetch-side and decode-side signals of the instruction fetch queue.
// slave = the queue itself, master = the fetch/decode environment around it.
interface riscv_ifq_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              ifu_vld;
    riscv_pkg::ifu_t   ifu;
    logic              fetch_stall;
    logic              ifq_vld;
    riscv_pkg::ifq_t   ifq;
    logic              ifq_ack;
    logic [CNT_W-1:0]  ifq_count;
    logic              ifq_overflow;

    modport slave (
        input  ifu_vld,
        input  ifu,
        input  ifq_ack,
        output fetch_stall,
        output ifq_vld,
        output ifq,
        output ifq_count,
        output ifq_overflow
    );

    modport master (
        output ifu_vld,
        output ifu,
        output ifq_ack,
        input  fetch_stall,
        input  ifq_vld,
        input  ifq,
        input  ifq_count,
        input  ifq_overflow
    );

endinterface

// File: rtl/riscv_ifq_predecode.sv
// Push-time predecode: annotates a fetched instruction with its size and the
// sequential next address. RVC expansion will slot in here later.
module riscv_ifq_predecode
    import riscv_pkg::*;
(
    input  ifu_t ifu,
    output ifq_t entry
);

    logic        is_rvc;
    logic [31:0] ilen;

    always_comb begin
        is_rvc = riscv_is_compressed(ifu.data[1:0]);
        ilen   = is_rvc ? ILEN_RVC : ILEN_RV;

        entry               = '0;
        entry.addr          = ifu.addr;
        entry.data          = ifu.data;
        entry.is_compressed = is_rvc;
        // 32-bit add wraps naturally past the top of the address space
        entry.next_addr     = ifu.addr + ilen;
    end

endmodule

// File: rtl/riscv_ifq.sv
// Instruction fetch queue: circular buffer between fetch and decode with
// fetch throttling, flush and a sticky overflow flag.
module riscv_ifq
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned STALL_MARGIN = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    riscv_ifq_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifq_t             pre_entry;
    ifq_t             mem_q [DEPTH];
    ifq_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] free_slots;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    riscv_ifq_predecode u_predecode (
        .ifu   (bus.ifu),
        .entry (pre_entry)
    );

    always_comb begin
        pop  = (count_q != '0) && bus.ifq_ack;
        full = (count_q == CNT_W'(DEPTH));
        // A full queue still accepts a push when the head leaves in the same cycle
        push = bus.ifu_vld && !flush && (!full || pop);
        drop = bus.ifu_vld && !flush && full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        mem_d      = mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                mem_d[wr_ptr_q] = pre_entry;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage needs no reset: it is only observed while ifq_vld is high.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;
    end

    assign bus.fetch_stall  = (free_slots <= CNT_W'(STALL_MARGIN));
    assign bus.ifq_vld      = (count_q != '0);
    assign bus.ifq          = mem_q[rd_ptr_q];
    assign bus.ifq_count    = count_q;
    assign bus.ifq_overflow = overflow_q;

endmodule

// File: tb/tb_riscv_ifq.sv
// Directed bench for riscv_ifq: fill/drain, RVC mix, full push+pop with wrap,
// overflow, flush and mid-stream reset, plus per-cycle invariants.
module tb_riscv_ifq;
    import riscv_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clock;
    logic reset;
    logic flush;
    int   total;
    int   bad;

    riscv_ifq_if #(.DEPTH(DEPTH)) bus ();

    riscv_ifq #(.DEPTH(DEPTH), .STALL_MARGIN(2)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then verify hold / full / bound invariants.
    task automatic tick();
        logic       pv, pa, pf, pr, piv;
        ifq_t       pq;
        logic [3:0] pc;
        pv  = bus.ifq_vld;
        pa  = bus.ifq_ack;
        pf  = flush;
        pr  = reset;
        piv = bus.ifu_vld;
        pq  = bus.ifq;
        pc  = bus.ifq_count;
        @(posedge clock);
        #1;
        if (!pr && !pf) begin
            if (pv && !pa) begin
                chk("hold_vld", bus.ifq_vld, 1);
                chk("hold_ifq", bus.ifq, pq);
            end
            if (pc == 4'd8 && piv && !(pv && pa))
                chk("full_nopush", bus.ifq_count, 8);
        end
        chk("cnt_max", bus.ifq_count <= 4'd8, 1);
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ifu_vld   = 1'b1;
            bus.ifu.addr  = base + 32'(4 * i);
            bus.ifu.data  = 32'h0000_0013;
            tick();
        end
        bus.ifu_vld = 1'b0;
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        bus.ifu_vld  = 1'b1;
        bus.ifu.addr = a;
        bus.ifu.data = d;
        tick();
        bus.ifu_vld  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        flush = 1'b0;
        bus.ifu_vld = 1'b0;
        bus.ifu     = '0;
        bus.ifq_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_vld",   bus.ifq_vld, 0);
        chk("rst_count", bus.ifq_count, 0);
        chk("rst_stall", bus.fetch_stall, 0);
        chk("rst_ovf",   bus.ifq_overflow, 0);

        // Fill: stall from count 6
        for (int i = 0; i < 8; i++) begin
            bus.ifu_vld  = 1'b1;
            bus.ifu.addr = 32'h200 + 32'(4 * i);
            bus.ifu.data = 32'h0000_0013;
            if (i == 0) chk("no_bypass", bus.ifq_vld, 0);
            tick();
            chk("fill_count", bus.ifq_count, i + 1);
            chk("fill_stall", bus.fetch_stall, (i + 1) >= 6);
        end
        bus.ifu_vld = 1'b0;
        chk("fill_head", bus.ifq.addr, 32'h200);

        // Drain in order
        bus.ifq_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_addr", bus.ifq.addr, 32'h200 + 32'(4 * i));
            chk("drain_next", bus.ifq.next_addr, 32'h204 + 32'(4 * i));
            chk("drain_rvc",  bus.ifq.is_compressed, 0);
            tick();
            chk("drain_count", bus.ifq_count, 7 - i);
        end
        bus.ifq_ack = 1'b0;
        chk("drain_vld", bus.ifq_vld, 0);

        // Compressed mix
        push1(32'h200, 32'h0000_4501);
        push1(32'h202, 32'h00A0_0093);
        chk("rvc_addr", bus.ifq.addr, 32'h200);
        chk("rvc_flag", bus.ifq.is_compressed, 1);
        chk("rvc_next", bus.ifq.next_addr, 32'h202);
        bus.ifq_ack = 1'b1;
        tick();
        bus.ifq_ack = 1'b0;
        chk("rv_addr", bus.ifq.addr, 32'h202);
        chk("rv_data", bus.ifq.data, 32'h00A0_0093);
        chk("rv_flag", bus.ifq.is_compressed, 0);
        chk("rv_next", bus.ifq.next_addr, 32'h206);
        bus.ifq_ack = 1'b1;
        tick();
        bus.ifq_ack = 1'b0;
        chk("rvc_empty", bus.ifq_count, 0);

        // Full with simultaneous push and pop; pointers start at 2 so they wrap
        fill(32'h300, 8);
        chk("full_count", bus.ifq_count, 8);
        for (int k = 0; k < 3; k++) begin
            bus.ifu_vld  = 1'b1;
            bus.ifu.addr = 32'h320 + 32'(4 * k);
            bus.ifu.data = 32'h0000_0013;
            bus.ifq_ack  = 1'b1;
            chk("pp_head", bus.ifq.addr, 32'h300 + 32'(4 * k));
            tick();
            chk("pp_count", bus.ifq_count, 8);
            chk("pp_ovf",   bus.ifq_overflow, 0);
        end
        bus.ifu_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("pp_order", bus.ifq.addr, 32'h30C + 32'(4 * k));
            tick();
        end
        bus.ifq_ack = 1'b0;
        chk("pp_empty", bus.ifq_count, 0);

        // Overflow: drop, sticky across flush
        fill(32'h500, 8);
        push1(32'h5FC, 32'h0000_0013);
        chk("ovf_flag",  bus.ifq_overflow, 1);
        chk("ovf_count", bus.ifq_count, 8);
        chk("ovf_head",  bus.ifq.addr, 32'h500);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("ovf_fl_count", bus.ifq_count, 0);
        chk("ovf_sticky",   bus.ifq_overflow, 1);

        // Flush with contents plus same-cycle push and ack
        fill(32'h600, 5);
        chk("fl_pre", bus.ifq_count, 5);
        flush        = 1'b1;
        bus.ifu_vld  = 1'b1;
        bus.ifu.addr = 32'h6FC;
        bus.ifq_ack  = 1'b1;
        tick();
        flush       = 1'b0;
        bus.ifu_vld = 1'b0;
        bus.ifq_ack = 1'b0;
        chk("fl_count", bus.ifq_count, 0);
        chk("fl_vld",   bus.ifq_vld, 0);
        push1(32'h400, 32'h0000_0013);
        chk("fl_new_vld",  bus.ifq_vld, 1);
        chk("fl_new_addr", bus.ifq.addr, 32'h400);
        chk("fl_new_cnt",  bus.ifq_count, 1);
        bus.ifq_ack = 1'b1;
        tick();
        bus.ifq_ack = 1'b0;

        // Address wrap of next_addr
        push1(32'hFFFF_FFFC, 32'h0000_0013);
        push1(32'hFFFF_FFFE, 32'h0000_0001);
        chk("wrap4", bus.ifq.next_addr, 32'h0);
        bus.ifq_ack = 1'b1;
        tick();
        chk("wrap2", bus.ifq.next_addr, 32'h0);
        chk("wrap2_rvc", bus.ifq.is_compressed, 1);
        tick();
        bus.ifq_ack = 1'b0;

        // Reset mid-stream with a push pending
        fill(32'h700, 3);
        chk("rs_pre", bus.ifq_count, 3);
        reset        = 1'b1;
        bus.ifu_vld  = 1'b1;
        bus.ifu.addr = 32'h70C;
        tick();
        reset       = 1'b0;
        bus.ifu_vld = 1'b0;
        chk("rs_vld",   bus.ifq_vld, 0);
        chk("rs_count", bus.ifq_count, 0);
        chk("rs_stall", bus.fetch_stall, 0);
        chk("rs_ovf",   bus.ifq_overflow, 0);
        tick();
        chk("rs_idle", bus.ifq_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_ifq.md
Name: riscv_ifq

Overview:
- Instruction fetch queue between riscv_ifu and the decode stage.
- Captures every valid instruction from riscv_ifu, since riscv_ifu has no backpressure input.
- Annotates each entry with predecode fields and presents entries in order to decode with a valid/ack handshake.
- Drives a throttle signal back to fetch and empties on pipeline flush.

Parameters:
- DEPTH, 8, number of queue entries. Must be a power of two, at least 4.
- STALL_MARGIN, 2, fetch_stall asserts when free entries are at or below this value. Covers instructions already in flight in riscv_ifu.

Ports:
- clock  input  1  single clock for the block
- reset  input  1  synchronous, active-high reset
- flush  input  1  pipeline flush, shared with riscv_ifu
- ifu_vld  input  1  instruction valid from riscv_ifu
- ifu  input  riscv_pkg::ifu_t  instruction address (32 bits) and data (32 bits; upper 16 bits are zero for compressed instructions)
- fetch_stall  output  1  throttle request to riscv_ifu
- ifq_vld  output  1  head entry is valid
- ifq  output  riscv_pkg::ifq_t  head entry: addr, data, is_compressed, next_addr
- ifq_ack  input  1  decode consumes the head entry this cycle
- ifq_count  output  $clog2(DEPTH)+1  current occupancy
- ifq_overflow  output  1  sticky error flag: a push was dropped

Behaviour:
- Reset values: ifq_vld=0, ifq_count=0, fetch_stall=0, ifq_overflow=0, both pointers 0. The ifq payload is don't-care while ifq_vld=0.
- Storage is a DEPTH-entry circular buffer with write pointer wr_ptr and read pointer rd_ptr.
  - Each pointer is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
  - count tracks occupancy separately, with range 0..DEPTH.
- Predecode is computed at push time and stored with the entry:
  - is_compressed = (ifu.data[1:0] != 2'b11)
  - next_addr = ifu.addr + (is_compressed ? 2 : 4), modulo 2^32 (wraps at 0xFFFFFFFE/0xFFFFFFFC)
- Push occurs when ifu_vld=1, flush=0, and the queue is not full after accounting for this cycle's pop.
  - Full with a simultaneous pop is accepted: pop and push happen together and count is unchanged.
- Pop occurs when ifq_vld=1 and ifq_ack=1. ifq_ack while ifq_vld=0 is ignored.
- Latency: a pushed entry is visible at ifq on the cycle after the push. There is no same-cycle bypass when the queue is empty.
- Outputs are driven from registered storage and registered count: ifq_vld = (count != 0); the payload is the entry at rd_ptr.
- Hold rule: ifq and ifq_vld stay stable until ack. The head is never replaced without a pop.
- Count update: count_next = count + push - pop.
- fetch_stall = ((DEPTH - count) <= STALL_MARGIN), computed from registered count, so it asserts combinationally from state.
- Overflow: ifu_vld=1 with the queue full, no pop, and flush=0:
  - the push is dropped;
  - ifq_overflow sets the next cycle and stays set until reset;
  - the queue contents are unchanged.
- Flush (highest priority after reset):
  - next cycle count=0 and rd_ptr=wr_ptr=0;
  - the same-cycle push is discarded;
  - the same-cycle ack is irrelevant;
  - ifq_vld=0 on the cycle after flush;
  - ifq_overflow is unaffected.
- Reset mid-operation overrides flush, push and pop. All state returns to reset values on the next cycle.
- Assertions (bench side):
  - ifq stable while ifq_vld && !ifq_ack;
  - count never exceeds DEPTH;
  - no push while count==DEPTH without a same-cycle pop.

Decomposition:
- riscv_pkg gains typedef ifq_t: addr[31:0], data[31:0], is_compressed, next_addr[31:0].
- riscv_pkg gains function riscv_is_compressed(logic [1:0]), reused by decode.
- One sub-module is natural: riscv_ifq_predecode.
  - Combinational; converts ifu_t to ifq_t.
  - Isolated so RVC-to-32-bit expansion can be added later without touching queue control.
- Queue control (pointers, count, stall, overflow) stays in riscv_ifq.

Test Plan:
- Fill and drain: push 8 instructions at addrs 0x200..0x21C (data 0x00000013) with ifq_ack=0.
  - count reaches 8; fetch_stall=1 from count=6.
  - Then ack every cycle: 8 entries emerge in order, next_addr=addr+4, and count returns to 0.
- Compressed mix: push addr 0x200 data 0x00004501, then addr 0x202 data 0x00A00093.
  - Head 1: is_compressed=1, next_addr=0x202.
  - Head 2: is_compressed=0, next_addr=0x206.
- Full with simultaneous push and pop: at count=8, hold ifu_vld=1 and ifq_ack=1 for 3 cycles.
  - count stays 8; ifq_overflow stays 0; order is preserved across the pointer wrap.
- Overflow: at count=8, drive ifu_vld=1 with ifq_ack=0.
  - The entry is dropped; ifq_overflow=1 next cycle and remains 1 after a subsequent flush.
- Flush with contents: at count=5, assert flush together with ifu_vld=1 and ifq_ack=1.
  - Next cycle count=0, ifq_vld=0.
  - Then push addr 0x400: it appears at the head one cycle later.
- Reset mid-stream: at count=3, assert reset for 1 cycle while ifu_vld=1.
  - Next cycle ifq_vld=0, count=0, fetch_stall=0, ifq_overflow=0.
